// File: rtl/bcd_pkg.sv
// Shared types and digit arithmetic for BCD conversion and display paths.
// Latency: n/a (package only).
// Backpressure: n/a.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  // Double-dabble pre-shift correction: a digit >= 5 would become >= 10 once
  // doubled, so bias it by 3 so the doubling carries into the next digit.
  function automatic logic [BCD_DIGIT_W-1:0] add3_if_ge5(input logic [BCD_DIGIT_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit slice of the double-dabble shifter: correct, then shift left.
// Latency: combinational.
// Backpressure: none; the parent register decides when the result is taken.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  input  logic                   carry_in,
  output logic [BCD_DIGIT_W-1:0] digit_out,
  output logic                   carry_out
);

  logic [BCD_DIGIT_W-1:0] corrected;

  // Corrected digit shifts up one place; its top bit moves to the next digit.
  always_comb begin
    corrected = add3_if_ge5(digit_in);
    digit_out = {corrected[BCD_DIGIT_W-2:0], carry_in};
    carry_out = corrected[BCD_DIGIT_W-1];
  end

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Iterative binary-to-BCD converter (double dabble), one operand bit per clock.
// Latency: BIN_W+1 edges from the accepting edge until done is visible.
// Backpressure: start is honoured only in IDLE or DONE; start during SHIFT is dropped.
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 17,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          ovf,
  output logic [DIGITS-1:0]             blank
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  // A displayed zero keeps only the units digit lit.
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  state_t             state;
  logic [BIN_W-1:0]   shreg;
  logic [BCD_W-1:0]   work;
  logic [BCD_W-1:0]   work_next;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_sticky;
  logic [DIGITS:0]    carry;
  logic [DIGITS-1:0]  blank_next;
  logic               all_zero;

  assign carry[0] = shreg[BIN_W-1];

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_cell u_cell (
        .digit_in  (work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .carry_in  (carry[g]),
        .digit_out (work_next[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .carry_out (carry[g+1])
      );
    end
  endgenerate

  // Leading-zero mask of the value about to be published; units digit always shown.
  always_comb begin
    blank_next = '0;
    all_zero   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero      = all_zero & (work_next[k*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      blank_next[k] = all_zero;
    end
  end

  // Control FSM, datapath iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
      blank      <= BLANK_RST;
      shreg      <= '0;
      work       <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            shreg      <= bin;
            work       <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= CNT_W'(BIN_W - 1);
            busy       <= 1'b1;
            state      <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          shreg      <= shreg << 1;
          work       <= work_next;
          ovf_sticky <= ovf_sticky | carry[DIGITS];
          cnt        <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            bcd   <= work_next;
            ovf   <= ovf_sticky | carry[DIGITS];
            blank <= blank_next;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq: default 17-bit/5-digit instance plus an 8-bit/3-digit sweep instance.
// Latency: checks done arrives 18 edges after start for the default instance.
// Backpressure: checks that start during a conversion is dropped.
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic        ovf;
  logic [4:0]  blank;

  logic        s_start;
  logic [7:0]  s_bin;
  logic        s_busy;
  logic        s_done;
  logic [11:0] s_bcd;
  logic        s_ovf;
  logic [2:0]  s_blank;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq #(.BIN_W(17), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .blank(blank)
  );

  binary_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .bin(s_bin),
    .busy(s_busy), .done(s_done), .bcd(s_bcd), .ovf(s_ovf), .blank(s_blank)
  );

  // Pulse start for one cycle and return the number of edges until done is seen.
  task automatic do_conv(input logic [16:0] v, output int lat);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin = '0; s_start = 1'b0; s_bin = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (bcd !== 20'h0)      begin errors++; $display("FAIL reset_bcd got %h expected 00000", bcd); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %b expected 0", ovf); end
    checks++; if (blank !== 5'b11110) begin errors++; $display("FAIL reset_blank got %b expected 11110", blank); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    do_conv(17'd43456, lat);
    checks++; if (lat != 18)          begin errors++; $display("FAIL basic_latency got %0d expected 18", lat); end
    checks++; if (bcd !== 20'h43456)  begin errors++; $display("FAIL basic_bcd got %h expected 43456", bcd); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL basic_ovf got %b expected 0", ovf); end
    checks++; if (blank !== 5'b00000) begin errors++; $display("FAIL basic_blank got %b expected 00000", blank); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL basic_busy_with_done got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL basic_done_pulse got %b expected 0", done); end
  endtask

  task automatic test_small_values();
    int lat;
    do_conv(17'd999, lat);
    checks++; if (bcd !== 20'h00999)  begin errors++; $display("FAIL v999_bcd got %h expected 00999", bcd); end
    checks++; if (blank !== 5'b11000) begin errors++; $display("FAIL v999_blank got %b expected 11000", blank); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL v999_ovf got %b expected 0", ovf); end
    do_conv(17'd0, lat);
    checks++; if (lat != 18)          begin errors++; $display("FAIL v0_latency got %0d expected 18", lat); end
    checks++; if (bcd !== 20'h00000)  begin errors++; $display("FAIL v0_bcd got %h expected 00000", bcd); end
    checks++; if (blank !== 5'b11110) begin errors++; $display("FAIL v0_blank got %b expected 11110", blank); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL v0_ovf got %b expected 0", ovf); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] vals [3] = '{17'd111, 17'd22222, 17'd65535};
    logic [19:0] exps [3] = '{20'h00111, 20'h22222, 20'h65535};
    int lat;
    @(negedge clk);
    bin   = vals[0];
    start = 1'b1;
    lat   = 0;
    while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    checks++; if (lat != 18)        begin errors++; $display("FAIL b2b_first_latency got %0d expected 18", lat); end
    checks++; if (bcd !== exps[0])  begin errors++; $display("FAIL b2b_bcd0 got %h expected %h", bcd, exps[0]); end
    for (int i = 1; i < 3; i++) begin
      bin = vals[i];
      if (i == 2) begin
        // start stays high only until this conversion is accepted
        @(negedge clk); start = 1'b0; lat = 1;
      end else begin
        lat = 0;
      end
      @(negedge clk); lat++;
      while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
      checks++; if (lat != 18)       begin errors++; $display("FAIL b2b_period%0d got %0d expected 18", i, lat); end
      checks++; if (bcd !== exps[i]) begin errors++; $display("FAIL b2b_bcd%0d got %h expected %h", i, bcd, exps[i]); end
      checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL b2b_ovf%0d got %b expected 0", i, ovf); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_after got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_start_ignored();
    int   lat;
    logic busy_ok;
    @(negedge clk);
    bin   = 17'd12345;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (lat == 4) begin bin = 17'd54321; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++; if (busy_ok !== 1'b1)  begin errors++; $display("FAIL ignore_busy_continuous got %b expected 1", busy_ok); end
    checks++; if (lat != 18)         begin errors++; $display("FAIL ignore_latency got %0d expected 18", lat); end
    checks++; if (bcd !== 20'h12345) begin errors++; $display("FAIL ignore_bcd got %h expected 12345", bcd); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ignore_no_requeue got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_overflow();
    int lat;
    do_conv(17'd100000, lat);
    checks++; if (bcd !== 20'h00000)  begin errors++; $display("FAIL ovf100k_bcd got %h expected 00000", bcd); end
    checks++; if (ovf !== 1'b1)       begin errors++; $display("FAIL ovf100k_ovf got %b expected 1", ovf); end
    checks++; if (blank !== 5'b11110) begin errors++; $display("FAIL ovf100k_blank got %b expected 11110", blank); end
    do_conv(17'd131071, lat);
    checks++; if (bcd !== 20'h31071)  begin errors++; $display("FAIL ovfmax_bcd got %h expected 31071", bcd); end
    checks++; if (ovf !== 1'b1)       begin errors++; $display("FAIL ovfmax_ovf got %b expected 1", ovf); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    bin   = 17'd43456;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rstmid_done got %b expected 0", done); end
    checks++; if (bcd !== 20'h0)      begin errors++; $display("FAIL rstmid_bcd got %h expected 00000", bcd); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL rstmid_ovf got %b expected 0", ovf); end
    checks++; if (blank !== 5'b11110) begin errors++; $display("FAIL rstmid_blank got %b expected 11110", blank); end
    do_conv(17'd43725, lat);
    checks++; if (lat != 18)          begin errors++; $display("FAIL rstmid_latency got %0d expected 18", lat); end
    checks++; if (bcd !== 20'h43725)  begin errors++; $display("FAIL rstmid_bcd_after got %h expected 43725", bcd); end
  endtask

  task automatic test_sweep_small();
    int          lat;
    logic [11:0] eb;
    logic [2:0]  ebl;
    for (int v = 0; v < 256; v++) begin
      eb  = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      ebl = {(v < 100), (v < 10), 1'b0};
      @(negedge clk);
      s_bin   = 8'(v);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      lat     = 1;
      while (s_done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      checks++; if (lat != 9)        begin errors++; $display("FAIL sweep_latency v=%0d got %0d expected 9", v, lat); end
      checks++; if (s_bcd !== eb)    begin errors++; $display("FAIL sweep_bcd v=%0d got %h expected %h", v, s_bcd, eb); end
      checks++; if (s_blank !== ebl) begin errors++; $display("FAIL sweep_blank v=%0d got %b expected %b", v, s_blank, ebl); end
      checks++; if (s_ovf !== 1'b0)  begin errors++; $display("FAIL sweep_ovf v=%0d got %b expected 0", v, s_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small_values();
    test_back_to_back();
    test_start_ignored();
    test_overflow();
    test_reset_mid();
    test_sweep_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
